// File: rtl/seq_calculator.sv
// seq_calculator: handshaked add/sub/mul/div unit with a 2W-bit registered result and status flags.
// Latency: add/sub/mul and divide-by-zero 1 cycle; divide W+1 cycles (restoring, one quotient bit per cycle).
// Backpressure: in_ready only in IDLE; result, div_by_zero and sat hold in DONE until out_ready.
//
// Ports: clk/rst (synchronous, active-high); in_valid/in_ready with first_num, second_num, operation
// (00 add, 01 sub, 10 mul, 11 div); out_valid/out_ready with out, div_by_zero, sat.
// Optional macro CALC_SAT_EN: subtraction with B>A clamps to 0 and raises sat; undefined, sub wraps
// to 2W bits and sat stays 0.
module seq_calculator #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     first_num,
    input  logic [W-1:0]     second_num,
    input  logic [1:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out,
    output logic             div_by_zero,
    output logic             sat
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   out_q, out_d;
    logic             dbz_q, dbz_d;
    logic             sat_q, sat_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     rem_q, rem_d;   // partial remainder
    logic [W-1:0]     dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [W-1:0]     dsr_q, dsr_d;   // divisor

    // Arithmetic for the single-cycle ops, evaluated on the live operands.
    logic [W:0]       sum;
    logic [2*W-1:0]   diff;
    logic [2*W-1:0]   prod;

    // One restoring-divide step.
    logic [W:0]       shifted;
    logic             q_bit;
    logic [W-1:0]     rem_next;
    logic [W-1:0]     dvd_next;

    always_comb begin
        sum      = {1'b0, first_num} + {1'b0, second_num};
        diff     = {{W{1'b0}}, first_num} - {{W{1'b0}}, second_num};
        prod     = {{W{1'b0}}, first_num} * {{W{1'b0}}, second_num};

        shifted  = {rem_q, dvd_q[W-1]};
        q_bit    = (shifted >= {1'b0, dsr_q});
        // When the trial subtraction succeeds the difference is below the divisor, so W bits hold it.
        rem_next = q_bit ? W'(shifted - {1'b0, dsr_q}) : shifted[W-1:0];
        dvd_next = {dvd_q[W-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        dbz_d   = dbz_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dbz_d   = 1'b0;
                    sat_d   = 1'b0;
                    state_d = S_DONE;
                    case (operation)
                        2'b00: out_d = {{(W-1){1'b0}}, sum};
                        2'b01: begin
`ifdef CALC_SAT_EN
                            if (second_num > first_num) begin
                                out_d = '0;
                                sat_d = 1'b1;
                            end else begin
                                out_d = diff;
                            end
`else
                            out_d = diff;
`endif
                        end
                        2'b10: out_d = prod;
                        default: begin
                            if (second_num == '0) begin
                                // Remainder is the dividend, quotient saturates to all ones.
                                out_d = {first_num, {W{1'b1}}};
                                dbz_d = 1'b1;
                            end else begin
                                dvd_d   = first_num;
                                dsr_d   = second_num;
                                rem_d   = '0;
                                cnt_d   = CW'(W);
                                state_d = S_DIV;
                            end
                        end
                    endcase
                end
            end
            S_DIV: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q - CW'(1);
                // Last step registers its own result directly so DONE follows without an extra cycle.
                if (cnt_q == CW'(1)) begin
                    out_d   = {rem_next, dvd_next};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            dbz_q   <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            dbz_q   <= dbz_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out         = out_q;
    assign div_by_zero = dbz_q;
`ifdef CALC_SAT_EN
    assign sat         = sat_q;
`else
    assign sat         = 1'b0;
`endif

endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: scoreboard bench for seq_calculator at W=8.
// Expected results are queued when an operation is issued and compared when out_valid && out_ready.
// Directed cases plus a short random sweep against an integer reference model.
module tb_seq_calculator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  first_num;
    logic [7:0]  second_num;
    logic [1:0]  operation;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        div_by_zero;
    logic        sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        dbz;
        logic        st;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    seq_calculator #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .first_num   (first_num),
        .second_num  (second_num),
        .operation   (operation),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .div_by_zero (div_by_zero),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Output side of the scoreboard: one pop per output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, " out"}, {16'd0, out}, {16'd0, mon_e.res});
                check({mon_e.tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                check({mon_e.tag, " sat"}, {31'd0, sat}, {31'd0, mon_e.st});
            end
        end
    end

    // Reference model, written from the arithmetic definitions.
    function automatic exp_t model(input int a, input int b, input int op, input string tag);
        exp_t e;
        e.tag = tag;
        e.dbz = 1'b0;
        e.st  = 1'b0;
        case (op)
            0: e.res = 16'(a + b);
            1: begin
`ifdef CALC_SAT_EN
                if (b > a) begin
                    e.res = 16'd0;
                    e.st  = 1'b1;
                end else begin
                    e.res = 16'(a - b);
                end
`else
                e.res = 16'((a - b + 65536) % 65536);
`endif
            end
            2: e.res = 16'(a * b);
            default: begin
                if (b == 0) begin
                    e.res = 16'((a << 8) | 255);
                    e.dbz = 1'b1;
                end else begin
                    e.res = 16'(((a % b) << 8) | (a / b));
                end
            end
        endcase
        return e;
    endfunction

    // Called #1 after a rising edge. Issues one op, checks latency and in_ready after the transfer.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input exp_t e, input int lat_exp);
        int n;
        sb.push_back(e);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check({tag, " in_ready timeout"}, 32'd0, 32'd1);
        first_num  = a;
        second_num = b;
        operation  = op;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, lat_exp);
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, " in_ready after transfer"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   a, b, op, n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        first_num  = '0;
        second_num = '0;
        operation  = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out", {16'd0, out}, 32'd0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        check("reset sat", {31'd0, sat}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // Directed cases.
        e = '{16'h012C, 1'b0, 1'b0, "add 200+100"};
        run_op(e.tag, 8'd200, 8'd100, 2'b00, e, 1);
`ifdef CALC_SAT_EN
        e = '{16'h0000, 1'b0, 1'b1, "sub 100-200"};
`else
        e = '{16'hFF9C, 1'b0, 1'b0, "sub 100-200"};
`endif
        run_op(e.tag, 8'd100, 8'd200, 2'b01, e, 1);
        e = '{16'h4E20, 1'b0, 1'b0, "mul 200*100"};
        run_op(e.tag, 8'd200, 8'd100, 2'b10, e, 1);
        e = '{16'h041C, 1'b0, 1'b0, "div 200/7"};
        run_op(e.tag, 8'd200, 8'd7, 2'b11, e, 9);
        e = '{16'hC8FF, 1'b1, 1'b0, "div 200/0"};
        run_op(e.tag, 8'd200, 8'd0, 2'b11, e, 1);
        e = '{16'h0002, 1'b0, 1'b0, "add 1+1"};
        run_op(e.tag, 8'd1, 8'd1, 2'b00, e, 1);

        // Backpressure: result held for 5 cycles while stray in_valid pulses are ignored.
        out_ready = 1'b0;
        sb.push_back('{16'h00FF, 1'b0, 1'b0, "mul 15*17 held"});
        first_num  = 8'd15;
        second_num = 8'd17;
        operation  = 2'b10;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            check("bp out stable", {16'd0, out}, 32'h00FF);
            first_num  = 8'd1;
            second_num = 8'd1;
            operation  = 2'b00;
            in_valid   = (i % 2 == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp out still held", {16'd0, out}, 32'h00FF);
        @(posedge clk); #1;
        check("bp completes on out_ready", {31'd0, out_valid}, 32'd0);
        check("bp in_ready after transfer", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a divide: the result must never appear.
        first_num  = 8'd255;
        second_num = 8'd3;
        operation  = 2'b11;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid-div reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid-div reset out", {16'd0, out}, 32'd0);
        rst = 1'b0;
        check("mid-div reset in_ready", {31'd0, in_ready}, 32'd1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("no stale result after reset", n, 32'd0);
        e = '{16'h0055, 1'b0, 1'b0, "div 255/3 after reset"};
        run_op(e.tag, 8'd255, 8'd3, 2'b11, e, 9);

        // Random sweep against the model.
        for (int i = 0; i < 24; i++) begin
            a  = $urandom_range(0, 255);
            b  = (i % 6 == 5) ? 0 : $urandom_range(0, 255);
            op = $urandom_range(0, 3);
            e  = model(a, b, op, $sformatf("rand%0d op%0d %0d,%0d", i, op, a, b));
            run_op(e.tag, 8'(a), 8'(b), 2'(op), e, (op == 3 && b != 0) ? 9 : 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_calculator.md
# seq_calculator

Parametrised, handshaked arithmetic unit: the multi-cycle successor to the team's 8-bit combinational four-operation calculator. Accepts one operation (add, sub, mul, div) per transaction on a valid/ready input port and returns a registered 2W-bit result on a valid/ready output port. Division is an iterative restoring divider, one quotient bit per cycle. Status flags report divide-by-zero and subtraction saturation.

## Interface

- `W`, default 8: operand width in bits (≥2).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset; one clock, synchronous, active-high.
- `in_valid` input 1: operand/op transfer request.
- `in_ready` output 1: unit can accept; high only in IDLE.
- `first_num` input W: operand A, unsigned.
- `second_num` input W: operand B, unsigned.
- `operation` input 2: 00 add, 01 sub, 10 mul, 11 div.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `out` output 2W: result.
- `div_by_zero` output 1: qualifies `out`; div with B=0.
- `sat` output 1: qualifies `out`; sub clamped (CALC_SAT_EN only).

## Operation

- States: IDLE, DIV, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, operands and op are captured.
  - add/sub/mul: result computed and registered; next state DONE.
  - div with B≠0: load dividend, clear remainder, counter=W; next state DIV.
  - div with B=0: next state DONE; `out` = {A (remainder), all-ones quotient}; `div_by_zero`=1.
- DIV: each cycle, shift the remainder left by one and bring in the next dividend MSB. Trial-subtract B; if the result is non-negative, keep it and set the quotient bit to 1. Decrement the counter. After W iterations, register the result; next state DONE.
- DONE: `out_valid`=1. `out` and the flags hold stable until `out_valid && out_ready`; then go to IDLE. A new transfer is never accepted in the same cycle as an output transfer.
- Result formats:
  - add: zero-extended A+B (W+1 significant bits).
  - sub: (A−B) mod 2^(2W), i.e. two's complement sign-extended to 2W.
  - mul: exact 2W-bit product.
  - div: `out[2W-1:W]`=remainder, `out[W-1:0]`=quotient.
- Flags are cleared on every accept. They are valid only while `out_valid`=1.
- Inputs are ignored outside IDLE and while `rst`=1.

## Timing

- Reset (synchronous, `rst` sampled high on a rising edge):
  - state → IDLE, `out_valid`=0, `out`=0, `div_by_zero`=0, `sat`=0, counter=0.
  - `in_ready`=1 from the first cycle after `rst` deasserts.
- Reset mid-operation (DIV or DONE): the operation is abandoned and the result is discarded; no `out_valid` pulse follows.
- Latency, from the accept edge to `out_valid` high:
  - add/sub/mul: 1 cycle.
  - div, B≠0: W+1 cycles.
  - div, B=0: 1 cycle.
- Minimum issue interval:
  - 2 cycles for single-cycle ops with `out_ready` held high.
  - W+2 cycles for div.
- `in_ready` is a combinational decode of state==IDLE. `out_valid` is a decode of state==DONE. Both are glitch-free registered-state decodes.
- Counter width: $clog2(W+1).

## Configuration

- `CALC_SAT_EN` defined: sub with B>A returns 0 and sets `sat`=1. Sub with B≤A is unchanged.
- `CALC_SAT_EN` undefined: sub wraps per the 2W-bit rule; `sat` is tied to 0. All other behaviour is identical.

## Test plan

All scenarios use W=8.

- Add A=200, B=100, op=00, `out_ready`=1 → `out`=0x012C one cycle after accept; `in_ready` returns high the cycle after the output transfer.
- Sub A=100, B=200, op=01:
  - without CALC_SAT_EN → `out`=0xFF9C, `sat`=0.
  - with CALC_SAT_EN → `out`=0x0000, `sat`=1.
- Mul A=200, B=100, op=10 → `out`=0x4E20, latency 1; then div A=200, B=7, op=11 → `out`=0x041C (r=4, q=28) exactly 9 cycles after accept.
- Div A=200, B=0 → `out`=0xC8FF, `div_by_zero`=1, latency 1. The following add 1+1 → `out`=0x0002, `div_by_zero`=0.
- Backpressure: mul 15×17 with `out_ready` low for 5 cycles → `out`=0x00FF held stable, `out_valid` high, `in_ready` low, and `in_valid` pulses during those cycles ignored; completes on the first cycle `out_ready`=1.
- Reset mid-divide: assert `rst` on cycle 3 of a 255/3 divide → the next cycle shows `out_valid`=0, `out`=0, `in_ready`=1 after release, no stale result. A fresh div 255/3 then yields `out`=0x0055.
